majority_vote_ctrl: RTL and testbench

//  Sequences one voting round for the 4-input Majority evaluator. Four voters share a single

---
 rtl/majority_vote_ctrl_pkg.sv | 20 ++
 rtl/majority_vote_ctrl_if.sv | 28 ++
 rtl/majority.sv | 20 ++
 rtl/majority_vote_ctrl_arb.sv | 29 ++
 rtl/majority_vote_ctrl.sv | 115 +++++++++++
 tb/tb_majority_vote_ctrl.sv | 179 +++++++++++++++++
 6 files changed

// File: rtl/majority_vote_ctrl_pkg.sv
// Shared types and constants for the majority voting round controller.
// Imported by the controller, the arbiter and the evaluator.
package majority_vote_ctrl_pkg;

  localparam int N_VOTERS = 4;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_EVAL    = 2'd2,
    S_DONE    = 2'd3
  } mv_state_t;

  typedef logic [N_VOTERS-1:0] vmask_t;

  function automatic logic [2:0] ones4(input vmask_t v);
    ones4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

// File: rtl/majority_vote_ctrl_if.sv
// Voter-side bus of the voting round controller.
// The master drives start and votes; the slave returns acks and results.
interface majority_vote_ctrl_if;
  import majority_vote_ctrl_pkg::*;

  logic   start;
  vmask_t vote_req;
  vmask_t vote_val;
  vmask_t vote_ack;
  logic   busy;
  logic   done;
  logic   result;
  logic   tie;
  vmask_t missing;

  modport master (
    output start, vote_req, vote_val,
    input  vote_ack, busy, done,
    input  result, tie, missing
  );

  modport slave (
    input  start, vote_req, vote_val,
    output vote_ack, busy, done,
    output result, tie, missing
  );

endinterface

// File: rtl/majority.sv
// Combinational 4-input majority evaluator.
// Y when three or more inputs are 1, Tie when exactly two are.
module Majority
  import majority_vote_ctrl_pkg::*;
(
  input  logic A,
  input  logic B,
  input  logic C,
  input  logic D,
  output logic Y,
  output logic Tie
);

  logic [2:0] w_ones;

  assign w_ones = ones4({A, B, C, D});
  assign Y      = (w_ones >= 3'd3);
  assign Tie    = (w_ones == 3'd2);

endmodule

// File: rtl/majority_vote_ctrl_arb.sv
// Combinational round-robin pick over four requesters.
// Search begins at ptr and wraps 3->0; gnt is one-hot or zero.
module rr_arbiter4
  import majority_vote_ctrl_pkg::*;
(
  input  vmask_t     eligible,
  input  logic [1:0] ptr,
  output vmask_t     gnt,
  output logic [1:0] gnt_idx
);

  logic [1:0] w_idx;

  // Walk from farthest to nearest so the slot closest to ptr wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = 2'd0;
    w_idx   = 2'd0;
    for (int k = N_VOTERS - 1; k >= 0; k--) begin
      w_idx = ptr + 2'(k);
      if (eligible[w_idx]) begin
        gnt          = '0;
        gnt[w_idx]   = 1'b1;
        gnt_idx      = w_idx;
      end
    end
  end

endmodule

// File: rtl/majority_vote_ctrl.sv
// Voting round controller: collects one vote per voter via a
// round-robin grant, with timeout, then registers the majority result.
module majority_vote_ctrl
  import majority_vote_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16,
  parameter int CNT_W       = 5
) (
  input logic                 clk,
  input logic                 rst,
  majority_vote_ctrl_if.slave bus
);

  mv_state_t  r_state;
  mv_state_t  w_next;
  vmask_t     r_voted;
  vmask_t     r_votes;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0] r_ptr;
  logic       r_result;
  logic       r_tie;
  vmask_t     r_missing;

  vmask_t     w_elig;
  vmask_t     w_gnt;
  vmask_t     w_ack;
  logic [1:0] w_gidx;
  logic       w_collect;
  logic       w_full;
  logic       w_expire;
  logic       w_maj_y;
  logic       w_maj_tie;

  assign w_collect = (r_state == S_COLLECT);
  assign w_elig    = w_collect ? (bus.vote_req & ~r_voted) : '0;

  rr_arbiter4 u_arb (
    .eligible (w_elig),
    .ptr      (r_ptr),
    .gnt      (w_gnt),
    .gnt_idx  (w_gidx)
  );

  assign w_ack    = w_collect ? w_gnt : '0;
  // Look at the mask including this cycle's grant so EVAL follows the 4th ack.
  assign w_full   = &(r_voted | w_ack);
  assign w_expire = (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

  Majority u_maj (
    .A   (r_votes[3]),
    .B   (r_votes[2]),
    .C   (r_votes[1]),
    .D   (r_votes[0]),
    .Y   (w_maj_y),
    .Tie (w_maj_tie)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    if (bus.start) w_next = S_COLLECT;
      S_COLLECT: if (w_full || w_expire) w_next = S_EVAL;
      S_EVAL:    w_next = S_DONE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_voted   <= '0;
      r_votes   <= '0;
      r_cnt     <= '0;
      r_ptr     <= 2'd0;
      r_result  <= 1'b0;
      r_tie     <= 1'b0;
      r_missing <= '0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_voted <= '0;
            r_votes <= '0;
            r_cnt   <= '0;
            r_ptr   <= 2'd0;
          end
        end
        S_COLLECT: begin
          r_cnt <= r_cnt + 1'b1;
          if (|w_ack) begin
            r_votes[w_gidx] <= bus.vote_val[w_gidx];
            r_voted         <= r_voted | w_ack;
            r_ptr           <= w_gidx + 2'd1;
          end
        end
        S_EVAL: begin
          r_result  <= w_maj_y;
          r_tie     <= w_maj_tie;
          r_missing <= ~r_voted;
        end
        default: ;
      endcase
    end
  end

  assign bus.vote_ack = w_ack;
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.done     = (r_state == S_DONE);
  assign bus.result   = r_result;
  assign bus.tie      = r_tie;
  assign bus.missing  = r_missing;

endmodule

// File: tb/tb_majority_vote_ctrl.sv
// Directed-vector bench for the majority voting round controller.
// Inputs change on the falling edge; outputs are checked just after it.
module tb_majority_vote_ctrl;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  majority_vote_ctrl_if bus ();

  majority_vote_ctrl #(
    .TIMEOUT_CYC (16),
    .CNT_W       (5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp_v);
    end
  endtask

  // Ends one falling edge after the start edge: first COLLECT cycle.
  task automatic start_round();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    #1;
  endtask

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic r,
                         input logic t, input logic [3:0] m);
    chk({tag, "_done"}, bus.done, 1'b1);
    chk({tag, "_res"}, bus.result, r);
    chk({tag, "_tie"}, bus.tie, t);
    chk({tag, "_miss"}, bus.missing, m);
  endtask

  initial begin
    n_vec        = 0;
    n_err        = 0;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.vote_req = 4'h0;
    bus.vote_val = 4'h0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_ack", bus.vote_ack, 4'h0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_res", bus.result, 1'b0);
    chk("rst_tie", bus.tie, 1'b0);
    chk("rst_miss", bus.missing, 4'h0);
    rst = 1'b0;

    // Case 1: all voters, three 1s
    bus.vote_req = 4'hF;
    bus.vote_val = 4'h7;
    start_round();
    chk("t1_busy", bus.busy, 1'b1);
    chk("t1_ack1", bus.vote_ack, 4'h1);
    nxt(); chk("t1_ack2", bus.vote_ack, 4'h2);
    nxt(); chk("t1_ack3", bus.vote_ack, 4'h4);
    nxt(); chk("t1_ack4", bus.vote_ack, 4'h8);
    nxt();
    chk("t1_eval_ack", bus.vote_ack, 4'h0);
    chk("t1_eval_done", bus.done, 1'b0);
    nxt(); chk_out("t1", 1'b1, 1'b0, 4'h0);
    nxt();
    chk("t1_done_off", bus.done, 1'b0);
    chk("t1_idle", bus.busy, 1'b0);
    chk("t1_hold", bus.result, 1'b1);
    bus.vote_req = 4'h0;

    // Case 3: two voters only, timeout path
    bus.vote_req = 4'h5;
    bus.vote_val = 4'h5;
    start_round();
    chk("t3_ack1", bus.vote_ack, 4'h1);
    nxt(); chk("t3_ack2", bus.vote_ack, 4'h4);
    repeat (14) nxt();
    chk("t3_c16_busy", bus.busy, 1'b1);
    chk("t3_c16_done", bus.done, 1'b0);
    nxt(); chk("t3_eval_done", bus.done, 1'b0);
    nxt(); chk_out("t3", 1'b0, 1'b1, 4'hA);
    bus.vote_req = 4'h0;
    nxt();

    // Case 4: voter0 held, others arrive later, rr wrap
    bus.vote_req = 4'h1;
    bus.vote_val = 4'hF;
    start_round();
    chk("t4_ack0", bus.vote_ack, 4'h1);
    nxt();
    chk("t4_held", bus.vote_ack, 4'h0);
    bus.vote_req = 4'hD;
    #1 chk("t4_ack_v2", bus.vote_ack, 4'h4);
    nxt();
    bus.vote_req = 4'hF;
    #1 chk("t4_ack_v3", bus.vote_ack, 4'h8);
    nxt(); chk("t4_ack_v1", bus.vote_ack, 4'h2);
    nxt(); chk("t4_eval_ack", bus.vote_ack, 4'h0);
    nxt(); chk_out("t4", 1'b1, 1'b0, 4'h0);
    bus.vote_req = 4'h0;
    nxt();

    // Case 5: reset in the 2nd COLLECT cycle
    bus.vote_req = 4'hF;
    bus.vote_val = 4'h3;
    start_round();
    nxt();
    rst = 1'b1;
    nxt();
    chk("t5_busy", bus.busy, 1'b0);
    chk("t5_ack", bus.vote_ack, 4'h0);
    chk("t5_done", bus.done, 1'b0);
    chk("t5_res", bus.result, 1'b0);
    rst = 1'b0;
    nxt();
    chk("t5_nodone", bus.done, 1'b0);
    chk("t5_idle", bus.busy, 1'b0);

    // Case 2: normal round after reset, tie
    start_round();
    chk("t2_ack1", bus.vote_ack, 4'h1);
    repeat (3) nxt();
    chk("t2_ack4", bus.vote_ack, 4'h8);
    nxt();
    nxt(); chk_out("t2", 1'b0, 1'b1, 4'h0);
    bus.vote_req = 4'h0;
    nxt();

    // Case 6: start while busy, voter 3 arrives in expiry cycle
    bus.vote_req = 4'h7;
    bus.vote_val = 4'hF;
    start_round();
    chk("t6_ack1", bus.vote_ack, 4'h1);
    nxt(); chk("t6_ack2", bus.vote_ack, 4'h2);
    nxt(); chk("t6_ack3", bus.vote_ack, 4'h4);
    bus.start = 1'b1;
    nxt();
    bus.start = 1'b0;
    chk("t6_noack", bus.vote_ack, 4'h0);
    chk("t6_busy", bus.busy, 1'b1);
    repeat (11) nxt();
    chk("t6_c15_ack", bus.vote_ack, 4'h0);
    chk("t6_c15_done", bus.done, 1'b0);
    nxt();
    bus.vote_req = 4'hF;
    #1 chk("t6_late_ack", bus.vote_ack, 4'h8);
    nxt();
    bus.vote_req = 4'h0;
    chk("t6_eval_done", bus.done, 1'b0);
    nxt(); chk_out("t6", 1'b1, 1'b0, 4'h0);
    nxt(); chk("t6_idle1", bus.busy, 1'b0);
    nxt(); chk("t6_idle2", bus.busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
